msk_mixcolumn_pipe: RTL and testbench

Pipelined, elastic masked (Inv)MixColumns unit for the 32-bit-datapath masked AES cores. It operates on one d-share column (4 bytes) per beat and selects MixColumns, InvMixColumns or bypass per beat. It holds a configurable number of register stages behind a valid/ready handshake and tags the fourth column of each state. The transform is linear, so each share is processed independently; no randomness is used and shares are never combined.

---
 rtl/msk_mixcolumn_pipe_pkg.sv | 26 ++
 rtl/msk_mixcolumn_pipe_if.sv | 26 ++
 rtl/msk_col_mix_share.sv | 49 ++++
 rtl/msk_mixcolumn_pipe.sv | 111 +++++++++++
 tb/tb_msk_mixcolumn_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msk_mixcolumn_pipe_pkg.sv
// Shared definitions for the masked (Inv)MixColumns pipe.
// Contents: per-beat mode encoding, the AES reduction polynomial, xtime, and
// the share/byte layout index helper used to (de)interleave a d-share column.
package msk_mixcolumn_pipe_pkg;

    typedef enum logic [1:0] {
        ModeMix       = 2'b00,
        ModeInvMix    = 2'b01,
        ModeBypass    = 2'b10,
        ModeBypassAlt = 2'b11
    } mode_e;

    localparam logic [7:0] GfPoly = 8'h1b;

    // Multiply by 2 in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GfPoly : 8'h00);
    endfunction

    // Position of bit i of share s within row (byte) r of a d-share column.
    function automatic int unsigned sh_bit_idx(input int unsigned d, input int unsigned r,
                                               input int unsigned i, input int unsigned s);
        return 8 * d * r + i * d + s;
    endfunction

endpackage

// File: rtl/msk_mixcolumn_pipe_if.sv
// Beat-level bus of the masked (Inv)MixColumns pipe.
// master: producer/consumer side (drives in_valid, in_mode, sh_col_in, out_ready, col_clr).
// slave : the pipe itself (drives in_ready, out_valid, sh_col_out, out_last).
interface msk_mixcolumn_pipe_if #(
    parameter int unsigned d = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [32*d-1:0]   sh_col_in;
    logic              out_valid;
    logic              out_ready;
    logic [32*d-1:0]   sh_col_out;
    logic              out_last;
    logic              col_clr;

    modport master (
        output in_valid, in_mode, sh_col_in, out_ready, col_clr,
        input  in_ready, out_valid, sh_col_out, out_last
    );

    modport slave (
        input  in_valid, in_mode, sh_col_in, out_ready, col_clr,
        output in_ready, out_valid, sh_col_out, out_last
    );
endinterface

// File: rtl/msk_col_mix_share.sv
// Combinational (Inv)MixColumns on a single share of one column.
// Ports: col   - 32-bit share column, row r in [8*r +: 8]
//        mode  - MixColumns, InvMixColumns or bypass
//        mixed - transformed share column, same layout
module msk_col_mix_share
    import msk_mixcolumn_pipe_pkg::*;
(
    input  logic [31:0] col,
    input  mode_e       mode,
    output logic [31:0] mixed
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[8*r +: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
    end

    // 2-bit indices wrap naturally, giving the mod-4 row rotation.
    always_comb begin
        mixed = col;
        for (int r = 0; r < 4; r++) begin
            case (mode)
                ModeMix: begin
                    mixed[8*r +: 8] = x2[2'(r)]
                                    ^ x2[2'(r + 1)] ^ a[2'(r + 1)]
                                    ^ a[2'(r + 2)]
                                    ^ a[2'(r + 3)];
                end
                ModeInvMix: begin
                    mixed[8*r +: 8] = (x8[2'(r)] ^ x4[2'(r)] ^ x2[2'(r)])
                                    ^ (x8[2'(r + 1)] ^ x2[2'(r + 1)] ^ a[2'(r + 1)])
                                    ^ (x8[2'(r + 2)] ^ x4[2'(r + 2)] ^ a[2'(r + 2)])
                                    ^ (x8[2'(r + 3)] ^ a[2'(r + 3)]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/msk_mixcolumn_pipe.sv
// Pipelined, elastic masked (Inv)MixColumns unit, one d-share column per beat.
// Ports: clk, syn_rst_n (synchronous, active-low)
//        bus (slave): in_valid/in_ready/in_mode/sh_col_in, out_valid/out_ready/
//                     sh_col_out/out_last, col_clr
// Shares are split, transformed independently and re-interleaved; the result is
// captured in stage 1 and carried unchanged through stages 2..PIPE.
module msk_mixcolumn_pipe
    import msk_mixcolumn_pipe_pkg::*;
#(
    parameter int unsigned d    = 2,
    parameter int unsigned PIPE = 1
) (
    input logic                 clk,
    input logic                 syn_rst_n,
    msk_mixcolumn_pipe_if.slave bus
);

    localparam int unsigned W = 32 * d;

    logic [31:0]     share_in  [d];
    logic [31:0]     share_out [d];
    logic [W-1:0]    mix_flat;

    for (genvar s = 0; s < d; s++) begin : g_share
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar i = 0; i < 8; i++) begin : g_bit
                assign share_in[s][8*r+i]            = bus.sh_col_in[sh_bit_idx(d, r, i, s)];
                assign mix_flat[sh_bit_idx(d, r, i, s)] = share_out[s][8*r+i];
            end
        end

        msk_col_mix_share u_mix (
            .col   (share_in[s]),
            .mode  (mode_e'(bus.in_mode)),
            .mixed (share_out[s])
        );
    end

    logic [PIPE-1:0] valid_q;
    logic [W-1:0]    data_q [PIPE];
    logic [1:0]      idx_q  [PIPE];
    logic [PIPE-1:0] load;
    logic [PIPE-1:0] up_valid;
    logic [W-1:0]    up_data [PIPE];
    logic [1:0]      up_idx  [PIPE];
    logic [1:0]      cnt_q, cnt_d, beat_idx;
    logic            accept;

    // A stage loads when empty or when its successor (or the output) takes its
    // beat this cycle; the chain makes in_ready combinational from out_ready.
    always_comb begin
        load = '0;
        load[PIPE-1] = ~valid_q[PIPE-1] | bus.out_ready;
        for (int k = int'(PIPE) - 2; k >= 0; k--) begin
            load[k] = ~valid_q[k] | load[k+1];
        end
    end

    assign accept   = bus.in_valid & load[0];
    assign beat_idx = bus.col_clr ? 2'd0 : cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = beat_idx + 2'd1;
        end else if (bus.col_clr) begin
            cnt_d = 2'd0;
        end
    end

    always_comb begin
        up_valid = '0;
        up_data  = '{default: '0};
        up_idx   = '{default: '0};
        up_valid[0] = bus.in_valid;
        up_data[0]  = mix_flat;
        up_idx[0]   = beat_idx;
        for (int k = 1; k < int'(PIPE); k++) begin
            up_valid[k] = valid_q[k-1];
            up_data[k]  = data_q[k-1];
            up_idx[k]   = idx_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!syn_rst_n) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
            idx_q   <= '{default: '0};
            cnt_q   <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < int'(PIPE); k++) begin
                if (load[k]) begin
                    valid_q[k] <= up_valid[k];
                    // Bubbles only clear the valid bit; data keeps its last beat.
                    if (up_valid[k]) begin
                        data_q[k] <= up_data[k];
                        idx_q[k]  <= up_idx[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready   = load[0];
    assign bus.out_valid  = valid_q[PIPE-1];
    assign bus.sh_col_out = data_q[PIPE-1];
    assign bus.out_last   = valid_q[PIPE-1] & (idx_q[PIPE-1] == 2'd3);

endmodule

// File: tb/tb_msk_mixcolumn_pipe.sv
// Self-checking bench: a PIPE=1 instance for known answers, modes and latency,
// and a PIPE=3 instance driven with randomized traffic against a scoreboard.
module tb_msk_mixcolumn_pipe;

    localparam int unsigned D = 2;
    localparam int unsigned W = 32 * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst3_n;

    msk_mixcolumn_pipe_if #(.d(D)) bus1 ();
    msk_mixcolumn_pipe_if #(.d(D)) bus3 ();

    msk_mixcolumn_pipe #(.d(D), .PIPE(1)) dut1 (
        .clk       (clk),
        .syn_rst_n (rst1_n),
        .bus       (bus1.slave)
    );

    msk_mixcolumn_pipe #(.d(D), .PIPE(3)) dut3 (
        .clk       (clk),
        .syn_rst_n (rst3_n),
        .bus       (bus3.slave)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa ^= 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_col(input logic [31:0] c, input logic [1:0] mode);
        logic [7:0]  coef [4];
        logic [31:0] o;
        if (mode[1]) return c;
        if (mode == 2'b00) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        else               coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                o[8*r +: 8] ^= gmul(coef[k], c[8*((r + k) % 4) +: 8]);
        return o;
    endfunction

    function automatic logic [31:0] share_of(input logic [W-1:0] v, input int s);
        logic [31:0] c;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 8; i++)
                c[8*r+i] = v[8*D*r + i*D + s];
        return c;
    endfunction

    function automatic logic [W-1:0] put_share(input logic [W-1:0] v, input int s,
                                               input logic [31:0] c);
        logic [W-1:0] o;
        o = v;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 8; i++)
                o[8*D*r + i*D + s] = c[8*r+i];
        return o;
    endfunction

    function automatic logic [W-1:0] ref_sh(input logic [W-1:0] v, input logic [1:0] mode);
        logic [W-1:0] o;
        o = '0;
        for (int s = 0; s < int'(D); s++) o = put_share(o, s, ref_col(share_of(v, s), mode));
        return o;
    endfunction

    function automatic logic [31:0] recomb(input logic [W-1:0] v);
        logic [31:0] x;
        x = '0;
        for (int s = 0; s < int'(D); s++) x ^= share_of(v, s);
        return x;
    endfunction

    function automatic logic [W-1:0] share_x(input logic [31:0] x);
        logic [W-1:0] v;
        logic [31:0]  acc, m;
        v   = '0;
        acc = x;
        for (int s = 0; s < int'(D) - 1; s++) begin
            m   = $urandom;
            v   = put_share(v, s, m);
            acc ^= m;
        end
        return put_share(v, int'(D) - 1, acc);
    endfunction

    // ---------------- PIPE=1 directed beats ----------------
    int cnt1 = 0;

    // Entered just after a rising edge; one beat, checked one cycle after acceptance.
    task automatic beat1(input logic [W-1:0] v, input logic [1:0] mode, input string tag,
                         output logic [W-1:0] got);
        bus1.in_valid  = 1'b1;
        bus1.in_mode   = mode;
        bus1.sh_col_in = v;
        @(negedge clk);
        check_val({tag, "_rdy"}, W'(bus1.in_ready), W'(1'b1));
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        got = bus1.sh_col_out;
        check_val({tag, "_vld"}, W'(bus1.out_valid), W'(1'b1));
        check_val({tag, "_data"}, bus1.sh_col_out, ref_sh(v, mode));
        check_val({tag, "_last"}, W'(bus1.out_last), W'(cnt1 == 3));
        cnt1 = (cnt1 + 1) % 4;
        @(posedge clk); #1;
    endtask

    // ---------------- PIPE=3 scoreboard ----------------
    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    logic         last_log[$];
    int           cnt3     = 0;
    int           out_seen = 0;
    int           acc_cnt  = 0;
    bit           last_acc = 0;
    bit           hold_pend = 0;
    logic [W-1:0] hold_data;
    logic         hold_last;
    int           idx3;

    always @(negedge clk) begin
        if (!rst3_n) begin
            exp_q.delete();
            cnt3      = 0;
            hold_pend = 0;
            last_acc  = 0;
        end else begin
            if (hold_pend) begin
                check_val("hold_vld", W'(bus3.out_valid), W'(1'b1));
                check_val("hold_data", bus3.sh_col_out, hold_data);
                check_val("hold_last", W'(bus3.out_last), W'(hold_last));
            end
            hold_pend = bus3.out_valid && !bus3.out_ready;
            hold_data = bus3.sh_col_out;
            hold_last = bus3.out_last;
            if (bus3.out_valid && bus3.out_ready) begin
                check_val("sb_underflow", W'(exp_q.size() == 0), W'(1'b0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("sb_data", bus3.sh_col_out, e.data);
                    check_val("sb_last", W'(bus3.out_last), W'(e.last));
                end
                last_log.push_back(bus3.out_last);
                out_seen++;
            end
            last_acc = bus3.in_valid && bus3.in_ready;
            if (last_acc) begin
                idx3   = bus3.col_clr ? 0 : cnt3;
                e.data = ref_sh(bus3.sh_col_in, bus3.in_mode);
                e.last = (idx3 == 3);
                exp_q.push_back(e);
                cnt3 = (idx3 + 1) % 4;
                acc_cnt++;
            end else if (bus3.col_clr) begin
                cnt3 = 0;
            end
        end
    end

    // One cycle of PIPE=3 traffic; new data only once the previous beat was taken.
    task automatic cyc3(input bit vld, input bit ordy, input bit clr);
        if (vld && (last_acc || !bus3.in_valid)) begin
            bus3.sh_col_in = share_x($urandom);
            bus3.in_mode   = 2'($urandom_range(0, 3));
        end
        bus3.in_valid  = vld;
        bus3.out_ready = ordy;
        bus3.col_clr   = clr;
        @(posedge clk); #1;
    endtask

    task automatic reset3(input string tag);
        bus3.in_valid = 1'b0;
        bus3.col_clr  = 1'b0;
        rst3_n        = 1'b0;
        @(posedge clk); #1;
        rst3_n = 1'b1;
        @(negedge clk);
        check_val({tag, "_ovld"}, W'(bus3.out_valid), W'(1'b0));
        check_val({tag, "_odata"}, bus3.sh_col_out, W'(0));
        check_val({tag, "_olast"}, W'(bus3.out_last), W'(1'b0));
        check_val({tag, "_irdy"}, W'(bus3.in_ready), W'(1'b1));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] v, got;
    logic [W-1:0] pv;
    logic [1:0]   pm, m;
    logic [8:0]   lv;
    int           base_acc, base_out, lat;

    initial begin
        bus1.in_valid = 0; bus1.in_mode = 0; bus1.sh_col_in = '0;
        bus1.out_ready = 1; bus1.col_clr = 0;
        bus3.in_valid = 0; bus3.in_mode = 0; bus3.sh_col_in = '0;
        bus3.out_ready = 1; bus3.col_clr = 0;
        rst1_n = 0; rst3_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst1_n = 1; rst3_n = 1;
        @(negedge clk);
        check_val("rst1_ovld", W'(bus1.out_valid), W'(1'b0));
        check_val("rst1_odata", bus1.sh_col_out, W'(0));
        check_val("rst1_olast", W'(bus1.out_last), W'(1'b0));
        check_val("rst1_irdy", W'(bus1.in_ready), W'(1'b1));
        check_val("rst3_ovld", W'(bus3.out_valid), W'(1'b0));
        check_val("rst3_irdy", W'(bus3.in_ready), W'(1'b1));
        @(posedge clk); #1;

        // Known answers on the PIPE=1 instance.
        v = share_x(32'h455313db);
        beat1(v, 2'b00, "kat_mix", got);
        check_val("kat_mix_rec", W'(recomb(got)), W'(32'hbca14d8e));
        v = share_x(32'hbca14d8e);
        beat1(v, 2'b01, "kat_inv", got);
        check_val("kat_inv_rec", W'(recomb(got)), W'(32'h455313db));
        v = share_x(32'h5c220af2);
        beat1(v, 2'b00, "kat_mix2", got);
        check_val("kat_mix2_rec", W'(recomb(got)), W'(32'h9d58dc9f));
        v = {$urandom, $urandom};
        beat1(v, 2'b10, "byp10", got);
        check_val("byp10_eq", got, v);
        v = {$urandom, $urandom};
        beat1(v, 2'b11, "byp11", got);
        check_val("byp11_eq", got, v);

        // Back-to-back random beats, mixed modes, one per cycle.
        for (int i = 0; i <= 12; i++) begin
            v = share_x($urandom);
            m = 2'($urandom_range(0, 3));
            bus1.in_valid  = (i < 12);
            bus1.in_mode   = m;
            bus1.sh_col_in = v;
            @(negedge clk);
            if (i < 12) check_val("b2b_rdy", W'(bus1.in_ready), W'(1'b1));
            if (i > 0) begin
                check_val("b2b_vld", W'(bus1.out_valid), W'(1'b1));
                check_val("b2b_data", bus1.sh_col_out, ref_sh(pv, pm));
                check_val("b2b_last", W'(bus1.out_last), W'(cnt1 == 3));
                cnt1 = (cnt1 + 1) % 4;
            end
            pv = v;
            pm = m;
            @(posedge clk); #1;
        end
        bus1.in_valid = 0;

        // PIPE=3 latency of a lone beat.
        reset3("r3a");
        cyc3(1, 1, 0);
        bus3.in_valid = 0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (bus3.out_valid) break;
        end
        check_val("lat3", W'(lat), W'(3));
        @(posedge clk); #1;
        repeat (3) cyc3(0, 1, 0);

        // Backpressure: fill the pipe, then drain.
        reset3("r3b");
        base_acc = acc_cnt;
        base_out = out_seen;
        repeat (5) cyc3(1, 0, 0);
        check_val("bp_accepted", W'(acc_cnt - base_acc), W'(3));
        @(negedge clk);
        check_val("bp_irdy", W'(bus3.in_ready), W'(1'b0));
        check_val("bp_ovld", W'(bus3.out_valid), W'(1'b1));
        @(posedge clk); #1;
        repeat (6) cyc3(0, 1, 0);
        check_val("bp_drained", W'(out_seen - base_out), W'(3));
        check_val("bp_empty", W'(exp_q.size()), W'(0));

        // Random elastic traffic.
        repeat (80) cyc3($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                         $urandom_range(0, 9) == 0);
        repeat (8) cyc3(0, 1, 0);
        check_val("rnd_empty", W'(exp_q.size()), W'(0));

        // Column indexing with col_clr on beat 6.
        reset3("r3c");
        last_log.delete();
        for (int b = 1; b <= 9; b++) cyc3(1, 1, b == 6);
        repeat (5) cyc3(0, 1, 0);
        check_val("clr_count", W'(last_log.size()), W'(9));
        lv = '0;
        for (int i = 0; i < last_log.size() && i < 9; i++) lv[i] = last_log[i];
        check_val("clr_last_pat", W'(lv), W'(9'b1_0000_1000));

        // Reset with two beats in flight.
        repeat (2) cyc3(1, 0, 0);
        reset3("r3d");
        last_log.delete();
        base_out = out_seen;
        cyc3(1, 1, 0);
        repeat (5) cyc3(0, 1, 0);
        check_val("mid_alone", W'(out_seen - base_out), W'(1));
        repeat (3) cyc3(1, 1, 0);
        repeat (5) cyc3(0, 1, 0);
        check_val("mid_count", W'(last_log.size()), W'(4));
        lv = '0;
        for (int i = 0; i < last_log.size() && i < 9; i++) lv[i] = last_log[i];
        check_val("mid_last_pat", W'(lv), W'(9'b0_0000_1000));
        check_val("end_empty", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
